// File: rtl/game_pkg.sv
// Shared definitions for the game-side logic: score width and ceiling,
// the score_keeper FSM state encoding and the default tick divider.
package game_pkg;

  localparam int SCORE_W = 12;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 12'h999;

  // One second at a 65 MHz system clock.
  localparam int TICK_DIV_DEFAULT = 65_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_inc3.sv
// Combinational 3-digit BCD incrementer that saturates at 999.
// The input is expected to hold valid BCD digits. Also used by the
// on-screen score display.
module bcd_inc3
  import game_pkg::*;
(
  input  logic [SCORE_W-1:0] in,
  output logic [SCORE_W-1:0] out
);

  logic [3:0] w_ones;
  logic [3:0] w_tens;
  logic [3:0] w_hund;

  assign w_ones = in[3:0];
  assign w_tens = in[7:4];
  assign w_hund = in[11:8];

  // Ripple a decimal carry from ones to hundreds; hold at the ceiling.
  always_comb begin
    out = in;
    if (in != SCORE_MAX) begin
      if (w_ones != 4'd9) begin
        out[3:0] = w_ones + 4'd1;
      end else begin
        out[3:0] = 4'd0;
        if (w_tens != 4'd9) begin
          out[7:4] = w_tens + 4'd1;
        end else begin
          out[7:4]  = 4'd0;
          out[11:8] = w_hund + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Score and end-of-game sequencer feeding the end screen.
// Counts landings as a BCD score, freezes it on a fall, pulses jump_fail,
// holds game_over while in OVER and produces a periodic one_sec_tick.
// Optional feature macro: SCORE_HIGH_SCORE_EN (tracks session best score).
//
// Inputs game_start / land_ok / fall are single-cycle pulses with no
// handshake: each is acted on in the cycle it is high, or ignored if the
// current state does not accept it. There is no back-pressure.
module score_keeper
  import game_pkg::*;
#(
  // Clock cycles per one_sec_tick period; must be at least 2.
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               game_start,
  input  logic               land_ok,
  input  logic               fall,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best_score,
  output logic               jump_fail,
  output logic               game_over,
  output logic               one_sec_tick,
  output state_t             dbg_state
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] w_score_nxt;
  logic [SCORE_W-1:0] w_score_inc;
  logic               r_jump_fail;
  logic               w_jump_fail_nxt;
  logic               r_game_over;
  logic               w_enter_over;
  logic [CNT_W-1:0]   r_tick_cnt;
  logic [CNT_W-1:0]   w_tick_cnt_nxt;
  logic               r_tick;

  bcd_inc3 u_bcd_inc3 (
    .in  (r_score),
    .out (w_score_inc)
  );

  // Next-state and next-score decode; fall beats land_ok, start beats all.
  always_comb begin
    w_state_nxt     = r_state;
    w_score_nxt     = r_score;
    w_jump_fail_nxt = 1'b0;
    w_enter_over    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (game_start) begin
          w_state_nxt = ST_RUN;
          w_score_nxt = '0;
        end
      end
      ST_RUN: begin
        if (fall) begin
          w_state_nxt     = ST_OVER;
          w_jump_fail_nxt = 1'b1;
          w_enter_over    = 1'b1;
        end else if (land_ok) begin
          w_score_nxt = w_score_inc;
        end
      end
      ST_OVER: begin
        if (game_start) begin
          w_state_nxt = ST_RUN;
          w_score_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered game outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_score     <= '0;
      r_jump_fail <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_score     <= w_score_nxt;
      r_jump_fail <= w_jump_fail_nxt;
      r_game_over <= (w_state_nxt == ST_OVER);
    end
  end

  // Free-running tick divider, restarted on entry to OVER so the first
  // blink arrives a full period after game_over rises.
  always_comb begin
    w_tick_cnt_nxt = r_tick_cnt + CNT_W'(1);
    if (w_enter_over || (r_tick_cnt == CNT_LAST)) begin
      w_tick_cnt_nxt = '0;
    end
  end

  // Tick counter and its registered terminal-count pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick_cnt_nxt;
      r_tick     <= (w_tick_cnt_nxt == CNT_LAST);
    end
  end

`ifdef SCORE_HIGH_SCORE_EN
  logic [SCORE_W-1:0] r_best;

  // Capture a new session best on the edge that enters OVER; BCD digits
  // compare correctly as a plain unsigned vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_best <= '0;
    end else if (w_enter_over && (r_score > r_best)) begin
      r_best <= r_score;
    end
  end

  assign best_score = r_best;
`else
  assign best_score = '0;
`endif

  assign score        = r_score;
  assign jump_fail    = r_jump_fail;
  assign game_over    = r_game_over;
  assign one_sec_tick = r_tick;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with TICK_DIV = 10.
// best_score expectations follow SCORE_HIGH_SCORE_EN as seen by this file.
module tb_score_keeper;
  import game_pkg::*;

  localparam int TDIV = 10;

  logic               clk;
  logic               rst_n;
  logic               game_start;
  logic               land_ok;
  logic               fall;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] best_score;
  logic               jump_fail;
  logic               game_over;
  logic               one_sec_tick;
  state_t             dbg_state;

  int n_tests;
  int n_fail;

  score_keeper #(.TICK_DIV(TDIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .game_start   (game_start),
    .land_ok      (land_ok),
    .fall         (fall),
    .score        (score),
    .best_score   (best_score),
    .jump_fail    (jump_fail),
    .game_over    (game_over),
    .one_sec_tick (one_sec_tick),
    .dbg_state    (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       gs;
    logic       lo;
    logic       fa;
    logic [11:0] exp_score;
    logic       exp_jf;
    logic       exp_go;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Apply inputs for one clock edge; returns at the following negedge.
  task automatic step(input logic gs, input logic lo, input logic fa);
    game_start = gs;
    land_ok    = lo;
    fall       = fa;
    @(posedge clk);
    @(negedge clk);
    game_start = 1'b0;
    land_ok    = 1'b0;
    fall       = 1'b0;
  endtask

  // Reference increment done through binary arithmetic.
  function automatic logic [11:0] model_inc(input logic [11:0] v);
    int n;
    n = int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    if (n < 999) n++;
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [11:0] exp_best(input logic [11:0] v);
`ifdef SCORE_HIGH_SCORE_EN
    return v;
`else
    return 12'h000;
`endif
  endfunction

  task automatic land_n(input int n, input string name);
    logic [11:0] exp;
    exp = score;
    for (int i = 0; i < n; i++) begin
      exp = model_inc(exp);
      step(1'b0, 1'b1, 1'b0);
      check(name, score, exp);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    game_start = 1'b0;
    land_ok    = 1'b0;
    fall       = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 12'h001, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 12'h002, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 12'h003, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 12'h003, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 12'h003, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 12'h003, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 12'h001, 1'b0, 1'b0};

    // 1. reset and first tick
    @(negedge clk);
    do_reset();
    check("rst_score", score, 12'h000);
    check("rst_best", best_score, 12'h000);
    check("rst_jf", 12'(jump_fail), 12'h0);
    check("rst_go", 12'(game_over), 12'h0);
    check("rst_tick", 12'(one_sec_tick), 12'h0);
    check("rst_state", 12'(dbg_state), 12'(ST_IDLE));
    for (int k = 1; k <= TDIV; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("tick_after_rst_%0d", k), 12'(one_sec_tick), (k == TDIV - 1) ? 12'h1 : 12'h0);
    end

    // 2. counting with decimal carries
    step(1'b1, 1'b0, 1'b0);
    check("start_score", score, 12'h000);
    check("start_state", 12'(dbg_state), 12'(ST_RUN));
    land_n(19, "count19");
    check("score_019", score, 12'h019);
    land_n(90, "count109");
    check("score_109", score, 12'h109);

    // 3. saturation at 999
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check("restart_score", score, 12'h000);
    land_n(999, "count999");
    check("score_999", score, 12'h999);
    step(1'b0, 1'b1, 1'b0);
    check("sat_999", score, 12'h999);

    // 4. land_ok and fall together at 042
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    land_n(42, "count42");
    step(1'b0, 1'b1, 1'b1);
    check("lf_score", score, 12'h042);
    check("lf_jf", 12'(jump_fail), 12'h1);
    check("lf_go", 12'(game_over), 12'h1);
    check("lf_best", best_score, exp_best(12'h042));
    check("lf_tick_k1", 12'(one_sec_tick), 12'h0);
    for (int k = 2; k <= TDIV; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 2) check("lf_jf_drop", 12'(jump_fail), 12'h0);
      check($sformatf("over_tick_k%0d", k), 12'(one_sec_tick), (k == TDIV) ? 12'h1 : 12'h0);
    end
    check("over_score_hold", score, 12'h042);

    // 5. best score only moves up
    step(1'b1, 1'b0, 1'b0);
    land_n(30, "count30");
    step(1'b0, 1'b0, 1'b1);
    check("g2_score", score, 12'h030);
    check("g2_best", best_score, exp_best(12'h042));
    step(1'b1, 1'b0, 1'b0);
    land_n(50, "count50");
    step(1'b0, 1'b0, 1'b1);
    check("g3_best", best_score, exp_best(12'h050));

    // Table of single-cycle input combinations
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].gs, vecs[i].lo, vecs[i].fa);
      check($sformatf("vec%0d_score", i), score, vecs[i].exp_score);
      check($sformatf("vec%0d_jf", i), 12'(jump_fail), 12'(vecs[i].exp_jf));
      check($sformatf("vec%0d_go", i), 12'(game_over), 12'(vecs[i].exp_go));
    end
    check("vec_best", best_score, exp_best(12'h050));

    // 6. asynchronous reset mid-RUN
    land_n(6, "count7");
    check("score_007", score, 12'h007);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_score", score, 12'h000);
    check("async_best", best_score, 12'h000);
    check("async_state", 12'(dbg_state), 12'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    check("idle_fall_jf", 12'(jump_fail), 12'h0);
    check("idle_fall_go", 12'(game_over), 12'h0);
    step(1'b0, 1'b1, 1'b0);
    check("idle_land_score", score, 12'h000);
    check("idle_state", 12'(dbg_state), 12'(ST_IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Game-side score and end-of-game sequencer sitting directly upstream of the end screen.
- Counts successful landings as a 3-digit BCD score and freezes it when the player falls.
- Issues the one-cycle `jump_fail` pulse and the level `game_over` that enables the end-screen overlay.
- Generates the `one_sec_tick` used to blink the end-screen prompt.
- Optionally tracks the best score of the session.

## Interface
Parameters:
- `TICK_DIV`, 65_000_000: clock cycles per `one_sec_tick` period; minimum 2.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `game_start`  in  1  one-cycle pulse: spacebar pressed on the start or end screen.
- `land_ok`  in  1  one-cycle pulse: player landed on a platform.
- `fall`  in  1  one-cycle pulse: player left the bottom of the screen.
- `score`  out  12  BCD score `{hundreds, tens, ones}`, registered.
- `best_score`  out  12  BCD session best, registered.
- `jump_fail`  out  1  one-cycle pulse on the fall that ends the game.
- `game_over`  out  1  level, high while in OVER; drives the end-screen `module_en`.
- `one_sec_tick`  out  1  one-cycle pulse every `TICK_DIV` cycles.

## Operation
The FSM has three states; its reset state is IDLE.
- IDLE → RUN on `game_start`. On this transition `score` clears to 12'h000.
- RUN:
  - `land_ok` increments `score` in BCD, with decimal carries between digits.
  - `score` saturates at 12'h999; a further `land_ok` leaves it at 12'h999.
  - `fall` → OVER. This pulses `jump_fail` and freezes `score`.
- OVER:
  - `score` holds its value.
  - `game_start` → RUN and clears `score` to 12'h000.
  - `land_ok` and `fall` are ignored.
- IDLE ignores `land_ok` and `fall`.
- RUN ignores `game_start`.

Simultaneous inputs:
- `land_ok` and `fall` in the same RUN cycle: `fall` wins, no increment, transition to OVER.
- `game_start` with any other input in OVER: the start wins, `score` becomes 0 and no increment occurs in that cycle.

Tick counter:
- Counts 0 … `TICK_DIV`-1 and then wraps.
- `one_sec_tick` is high in the cycle the counter holds `TICK_DIV`-1.
- The counter is forced to 0 on entry to OVER, so the first tick arrives exactly `TICK_DIV` cycles after `game_over` rises.

Reset values: `score` 12'h000, `best_score` 12'h000, `jump_fail` 0, `game_over` 0, `one_sec_tick` 0, state IDLE, tick counter 0.

Reset mid-game returns to IDLE immediately. `best_score` is cleared by reset.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `land_ok` sampled at edge N → new `score` visible after edge N.
- `fall` sampled at edge N:
  - `jump_fail` is high for exactly the cycle after edge N.
  - `game_over` rises after edge N.
  - `score` is stable from edge N onward.
- `game_start` sampled at edge N → `game_over` falls and `score` reads 0 after edge N.
- `best_score` updates after the edge that enters OVER, in the same cycle `game_over` rises.
- The end screen samples `score` on the rising edge of `game_over`, so `score` must already hold its final value at that point. It does, because it freezes on the same edge.

## Configuration
- `SCORE_HIGH_SCORE_EN` defined:
  - On entry to OVER, `best_score` loads `score` if `score` > `best_score`.
  - The comparison is an unsigned compare of the 12-bit vectors, which is valid for BCD.
- `SCORE_HIGH_SCORE_EN` undefined: `best_score` is a constant 12'h000 and no compare logic is built.

## Structure
- Shared package `game_pkg`:
  - `SCORE_W` = 12 and `SCORE_MAX` = 12'h999.
  - FSM state enum `{ST_IDLE, ST_RUN, ST_OVER}`.
  - `TICK_DIV` default for a 65 MHz clock.
- One sub-module, `bcd_inc3`:
  - Combinational 3-digit BCD incrementer with saturation.
  - Ports: `in[11:0]`, `out[11:0]`; `out` equals `in` when `in` is 12'h999.
  - Reusable by the on-screen score display.
- The tick counter width is $clog2(`TICK_DIV`).

## Test plan
Run with `TICK_DIV` = 10 and `SCORE_HIGH_SCORE_EN` defined.
1. Reset low for 3 cycles, then release → all outputs 0, no tick before 10 cycles have elapsed.
2. `game_start`, then 19 `land_ok` pulses → `score` = 12'h019; a further 90 pulses → 12'h109, checking digit carry at each step.
3. Preload with 999 landings, then 1 more `land_ok` → `score` stays 12'h999.
4. `land_ok` and `fall` in the same cycle at `score` = 12'h042:
   - `score` = 12'h042.
   - `jump_fail` high for 1 cycle.
   - `game_over` = 1.
   - `best_score` = 12'h042.
   - `one_sec_tick` exactly 10 cycles later.
5. Second game scores 12'h030, then `fall` → `best_score` stays 12'h042. Third game scores 12'h050 → `best_score` = 12'h050.
6. `rst_n` asserted asynchronously mid-RUN at `score` = 12'h007 → outputs clear before the next clock edge. A `fall` after release is ignored in IDLE.
